// File: rtl/io_display.sv
// io_display -- four-digit multiplexed seven-segment driver.
//
// Scans four digits, holding each active for REFRESH_DIV clock cycles. Digit 0 shows the
// CPU result nibble (led); digits 1..3 show sw[3:0], sw[7:4] and sw[11:8]. sw[15:12] is
// not used. AN and seg come straight from flops and change on the same edge, one cycle
// behind the digit index and input sampling.
//
// Optional feature: define IO_DISPLAY_DP_EN to light the decimal point on digit 0 as a
// marker for the result digit. Without it the decimal point stays dark.
//
// Ports:
//   CLK        system clock, rising edge
//   key_reset  asynchronous reset, active high; blanks the display
//   sw[15:0]   switch operand, sw[11:0] displayed
//   led[3:0]   CPU result nibble, displayed on digit 0
//   AN[3:0]    digit enables, active low, one-hot-low
//   seg[7:0]   segments, active low; seg[7]=dp, seg[6:0]=g..a
module io_display #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic        CLK,
  input  logic        key_reset,
  input  logic [15:0] sw,
  input  logic [3:0]  led,
  output logic [3:0]  AN,
  output logic [7:0]  seg
);

  // A divide of 1 needs no counting bits; keep one bit so the vector stays legal.
  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            wrap;

  logic [3:0] nibble;
  logic [3:0] an_d;
  logic [6:0] hex;
  logic       dp;
  logic [7:0] seg_d;

  // Refresh counter and digit index.
  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge CLK or posedge key_reset) begin
    if (key_reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Digit select and hex decode from the current index, registered below.
  always_comb begin
    nibble = 4'h0;
    an_d   = 4'b1111;
    unique case (idx_q)
      2'd0: begin nibble = led;      an_d = 4'b1110; end
      2'd1: begin nibble = sw[3:0];  an_d = 4'b1101; end
      2'd2: begin nibble = sw[7:4];  an_d = 4'b1011; end
      2'd3: begin nibble = sw[11:8]; an_d = 4'b0111; end
      default: begin nibble = 4'h0;  an_d = 4'b1111; end
    endcase
  end

  always_comb begin
    hex = 7'h7F;
    unique case (nibble)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  always_comb begin
`ifdef IO_DISPLAY_DP_EN
    dp = (idx_q == 2'd0) ? 1'b0 : 1'b1;
`else
    dp = 1'b1;
`endif
    seg_d = {dp, hex};
  end

  // AN and seg share one register stage so a digit never pairs with a stale pattern.
  always_ff @(posedge CLK or posedge key_reset) begin
    if (key_reset) begin
      AN  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      AN  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_io_display.sv
// Bench for io_display at REFRESH_DIV=4. A reference model of the scan predicts {AN,seg}
// for each edge; predictions are queued before the edge and compared just after it.
module tb_io_display;

  localparam int unsigned Div = 4;

  logic        CLK;
  logic        key_reset;
  logic [15:0] sw;
  logic [3:0]  led;
  logic [3:0]  AN;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int unsigned m_cnt = 0;
  int unsigned m_idx = 0;
  logic [11:0] sb_q[$];

  io_display #(.REFRESH_DIV(Div)) dut (
    .CLK      (CLK),
    .key_reset(key_reset),
    .sw       (sw),
    .led      (led),
    .AN       (AN),
    .seg      (seg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n, input int unsigned idx);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
`ifdef IO_DISPLAY_DP_EN
    if (idx == 0) s[7] = 1'b0;
`endif
    return s;
  endfunction

  function automatic logic [11:0] predict();
    logic [3:0] an;
    logic [3:0] n;
    case (m_idx)
      0: begin an = 4'b1110; n = led;      end
      1: begin an = 4'b1101; n = sw[3:0];  end
      2: begin an = 4'b1011; n = sw[7:4];  end
      default: begin an = 4'b0111; n = sw[11:8]; end
    endcase
    return {an, seg_of(n, m_idx)};
  endfunction

  // One clock edge: queue the prediction, advance the model, compare after the edge.
  task automatic step(input string tag);
    logic [11:0] exp;
    sb_q.push_back(predict());
    if (m_cnt == Div - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_an"},  {28'd0, AN},  {28'd0, exp[11:8]});
      check({tag, "_seg"}, {24'd0, seg}, {24'd0, exp[7:0]});
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    sb_q.delete();
  endtask

  initial begin
    key_reset = 1'b1;
    sw        = 16'h0000;
    led       = 4'h0;

    // Held in reset: blank regardless of clock.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("rst_an",  {28'd0, AN},  32'hF);
      check("rst_seg", {24'd0, seg}, 32'hFF);
    end

    // Release with led=5: first edge shows digit 0, held four cycles, then digit 1.
    key_reset = 1'b0;
    led       = 4'h5;
    model_reset();
    @(posedge CLK);
    #1;
    check("first_an",  {28'd0, AN},  32'hE);
    check("first_seg", {24'd0, seg}, {24'd0, seg_of(4'h5, 0)});
    m_cnt = 1;
    for (int i = 0; i < 3; i++) step("hold0");
    step("to_idx1");
    check("idx1_an", {28'd0, AN}, 32'hD);

    // Full scan of a switch operand.
    sw = 16'h0A3C;
    for (int i = 0; i < 20; i++) step("scan");

    // Run to the start of digit 0, then change led mid-digit.
    while (!(m_idx == 0 && m_cnt == 1)) step("align");
    led = 4'h0;
    step("led0");
    check("led0_seg", {24'd0, seg}, {24'd0, seg_of(4'h0, 0)});
    led = 4'hF;
    step("ledF");
    check("ledF_seg", {24'd0, seg}, {24'd0, seg_of(4'hF, 0)});
    check("ledF_an",  {28'd0, AN},  32'hE);

    // Ignored switch bits must not disturb any digit.
    sw = 16'hFA3C;
    for (int i = 0; i < 16; i++) step("sw_hi");

    // Decimal point behaviour on a full scan with led=8.
    led = 4'h8;
    for (int i = 0; i < 16; i++) step("dp");

    // Mid-scan reset between edges blanks at once and restarts from digit 0.
    step("pre_rst");
    #2;
    key_reset = 1'b1;
    #1;
    check("midrst_an",  {28'd0, AN},  32'hF);
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    @(posedge CLK);
    #1;
    check("midrst_hold_seg", {24'd0, seg}, 32'hFF);
    key_reset = 1'b0;
    led       = 4'h2;
    model_reset();
    for (int i = 0; i < 10; i++) step("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_display.md
IO_DISPLAY -- requirements
Module: io_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000, giving the number of CLK cycles each digit stays active; legal range 1..2^20.
REQ-002 SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port key_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port sw, input, 16 bits: board switches carrying the displayed operand; sw[15:12] are ignored.
REQ-005 SHALL have port led, input, 4 bits: CPU result nibble.
REQ-006 SHALL have port AN, output, 4 bits: digit enables, active-low, one-hot-low when not in reset.
REQ-007 SHALL have port seg, output, 8 bits: segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

Function
REQ-008 SHALL keep a refresh counter 0..REFRESH_DIV-1 that increments every cycle; at REFRESH_DIV-1 it wraps to 0 and the 2-bit digit index advances (3 wraps to 0).
REQ-009 With REFRESH_DIV=1, the digit index SHALL advance every cycle.
REQ-010 Digit-to-nibble mapping: index 0 = led; index 1 = sw[3:0]; index 2 = sw[7:4]; index 3 = sw[11:8].
REQ-011 AN SHALL drive low only the bit equal to the index: idx0 -> 1110, idx1 -> 1101, idx2 -> 1011, idx3 -> 0111.
REQ-012 seg[6:0] hex encoding (seg[7]=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-013 AN and seg SHALL be registered: values reflect the index and the sw/led sampled at the previous rising edge (1-cycle latency); no combinational path from inputs to outputs.
REQ-014 AN and seg SHALL change on the same edge, so a digit is never shown with a mismatched pattern.
REQ-015 Input changes SHALL take effect on the next edge for the digit currently active; no synchronisation or debounce is performed.
REQ-016 The counter width SHALL be the minimum needed for REFRESH_DIV; no overflow past REFRESH_DIV-1 is permitted.

Reset
REQ-017 While key_reset=1: counter=0, index=0, AN=4'b1111, seg=8'hFF (display blank), independent of CLK.
REQ-018 On the first rising edge after key_reset falls, AN SHALL be 1110 and seg SHALL show led; the counter counts from 0.
REQ-019 Reset asserted mid-scan SHALL abort the scan immediately; no partial state is kept.

Configuration
REQ-020 Macro IO_DISPLAY_DP_EN: when defined, seg[7] SHALL be 0 (dp lit) while index 0 is active, marking the result digit; when undefined, seg[7] SHALL always be 1.

Verification (REFRESH_DIV=4)
REQ-021 Hold key_reset=1 and toggle CLK -> AN=1111, seg=FF throughout; assert key_reset between edges -> outputs blank at once.
REQ-022 Release reset with led=4'h5 -> first edge AN=1110, seg=92; AN stays 1110 for 4 cycles, then becomes 1101.
REQ-023 Set sw=16'h0A3C and let the scan run -> AN 1101 seg C6; AN 1011 seg B0; AN 0111 seg 88; then back to AN 1110.
REQ-024 Change led from 0 to F while index 0 is active -> seg goes C0 to 8E exactly one edge later; AN unchanged.
REQ-025 Set sw[15:12]=F with other bits constant -> no output change on any digit.
REQ-026 With IO_DISPLAY_DP_EN defined and led=8 -> idx0 seg=00, other digits have seg[7]=1; undefined -> idx0 seg=80.
